iq_symbol_mapper: RTL and testbench

//  Parametrised multi-mode symbol source for the modulator chain. Supports BPSK, QPSK, 8PSK and QAM-16.
//  An internal PRBS-23 generator drives Gray-coded constellation maps. Output is an AXI-Stream IQ word.

---
 rtl/iq_symbol_mapper.sv | 139 +++++++++++++
 tb/tb_iq_symbol_mapper.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_symbol_mapper.sv
// Multi-mode PRBS-23 driven IQ symbol source (BPSK/QPSK/8PSK/QAM16).
// Emits Gray-mapped constellation points as an AXI-Stream IQ word.
module iq_symbol_mapper #(
    parameter int          IorQ_BW     = 16,
    parameter int          IQ_BW       = 32,
    parameter int          AMP         = 16384,
    parameter logic [22:0] LFSR_SEED   = 23'h7FFFFF,
    parameter logic [2:0]  DEFAULT_MOD = 3'b000
) (
    input  logic             samp_clk,
    input  logic             samp_rst,
    input  logic             run,
    input  logic [2:0]       mod_type,
    input  logic             mod_type_we,
    output logic             iq_out_TVALID,
    input  logic             iq_out_TREADY,
    output logic [IQ_BW-1:0] iq_out_TDATA,
    output logic [2:0]       cur_mod_type,
    output logic [31:0]      sym_count,
    output logic             mod_err
);

    if (IQ_BW != 2 * IorQ_BW) begin : g_bw_err
        $error("IQ_BW must equal 2*IorQ_BW");
    end
    if (AMP > 2 ** (IorQ_BW - 1) - 1) begin : g_amp_err
        $error("AMP exceeds signed component range");
    end
    if (LFSR_SEED == 23'd0) begin : g_seed_err
        $error("LFSR_SEED must be non-zero");
    end

    localparam logic [2:0] M_QPSK  = 3'b000;
    localparam logic [2:0] M_BPSK  = 3'b001;
    localparam logic [2:0] M_QAM16 = 3'b010;
    localparam logic [2:0] M_8PSK  = 3'b011;

    localparam longint H_INT = (longint'(AMP) * 23170) >>> 15;
    localparam longint L_INT = longint'(AMP) / 3;

    localparam logic signed [IorQ_BW-1:0] A_P  = IorQ_BW'(AMP);
    localparam logic signed [IorQ_BW-1:0] H_P  = IorQ_BW'(H_INT);
    localparam logic signed [IorQ_BW-1:0] L_P  = IorQ_BW'(L_INT);
    localparam logic signed [IorQ_BW-1:0] L3_P = IorQ_BW'(3 * L_INT);
    localparam logic signed [IorQ_BW-1:0] Z_P  = '0;

    logic [22:0] lfsr;
    logic [22:0] lfsr_nxt;
    logic [22:0] s1, s2, s3, s4;
    logic [2:0]  mod_pend;
    logic [2:0]  gray, phase;
    logic signed [IorQ_BW-1:0] i_nxt, q_nxt;
    logic load;

    function automatic logic signed [IorQ_BW-1:0] qam_lvl(input logic [1:0] b);
        case (b)
            2'b00:   return -L3_P;
            2'b01:   return -L_P;
            2'b11:   return L_P;
            default: return L3_P;
        endcase
    endfunction

    // Four unrolled Fibonacci steps; each new bit lands in bit 0.
    assign s1 = {lfsr[21:0], lfsr[22] ^ lfsr[17]};
    assign s2 = {s1[21:0], s1[22] ^ s1[17]};
    assign s3 = {s2[21:0], s2[22] ^ s2[17]};
    assign s4 = {s3[21:0], s3[22] ^ s3[17]};

    assign gray  = {s1[0], s2[0], s3[0]};
    assign phase = {gray[2], gray[2] ^ gray[1], ^gray};

    assign load = run && (!iq_out_TVALID || iq_out_TREADY);

    always_comb begin
        lfsr_nxt = s2;
        i_nxt    = s1[0] ? -H_P : H_P;
        q_nxt    = s2[0] ? -H_P : H_P;
        case (mod_pend)
            M_BPSK: begin
                lfsr_nxt = s1;
                i_nxt    = s1[0] ? -A_P : A_P;
                q_nxt    = Z_P;
            end
            M_QAM16: begin
                lfsr_nxt = s4;
                i_nxt    = qam_lvl({s1[0], s2[0]});
                q_nxt    = qam_lvl({s3[0], s4[0]});
            end
            M_8PSK: begin
                lfsr_nxt = s3;
                case (phase)
                    3'd0: begin i_nxt = A_P;  q_nxt = Z_P;  end
                    3'd1: begin i_nxt = H_P;  q_nxt = H_P;  end
                    3'd2: begin i_nxt = Z_P;  q_nxt = A_P;  end
                    3'd3: begin i_nxt = -H_P; q_nxt = H_P;  end
                    3'd4: begin i_nxt = -A_P; q_nxt = Z_P;  end
                    3'd5: begin i_nxt = -H_P; q_nxt = -H_P; end
                    3'd6: begin i_nxt = Z_P;  q_nxt = -A_P; end
                    default: begin i_nxt = H_P; q_nxt = -H_P; end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge samp_clk or posedge samp_rst) begin
        if (samp_rst) begin
            iq_out_TVALID <= 1'b0;
            iq_out_TDATA  <= '0;
            cur_mod_type  <= DEFAULT_MOD;
            mod_pend      <= DEFAULT_MOD;
            sym_count     <= 32'd0;
            mod_err       <= 1'b0;
            lfsr          <= LFSR_SEED;
        end else begin
            if (load) begin
                iq_out_TVALID <= 1'b1;
                iq_out_TDATA  <= {i_nxt, q_nxt};
                cur_mod_type  <= mod_pend;
                lfsr          <= lfsr_nxt;
            end else if (iq_out_TREADY) begin
                iq_out_TVALID <= 1'b0;
            end
            if (iq_out_TVALID && iq_out_TREADY) begin
                sym_count <= sym_count + 32'd1;
            end
            // A write is seen by loads from the next edge on.
            if (mod_type_we) begin
                if (mod_type[2]) begin
                    mod_err <= 1'b1;
                end else begin
                    mod_pend <= mod_type;
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_symbol_mapper.sv
// Self-checking bench for iq_symbol_mapper: per-cycle reference model
// plus hand-computed constellation points and corner sequences.
module tb_iq_symbol_mapper;

    localparam int A  = 16384;
    localparam int H  = 11585;
    localparam int L  = 5461;
    localparam int L3 = 16383;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [2:0]  mod_type = 3'b000;
    logic        we = 1'b0;
    logic        tready = 1'b0;
    logic        tvalid;
    logic [31:0] tdata;
    logic [2:0]  cur_mod;
    logic [31:0] count;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic        m_valid;
    logic [31:0] m_data;
    logic [2:0]  m_mode;
    logic [2:0]  m_pend;
    logic [31:0] m_count;
    logic        m_err;
    logic [22:0] m_lfsr;

    typedef struct {
        logic [2:0] mode;
        int         nsym;
        int         rdy_pct;
    } seg_t;

    seg_t segs[6];

    iq_symbol_mapper dut (
        .samp_clk      (clk),
        .samp_rst      (rst),
        .run           (run),
        .mod_type      (mod_type),
        .mod_type_we   (we),
        .iq_out_TVALID (tvalid),
        .iq_out_TREADY (tready),
        .iq_out_TDATA  (tdata),
        .cur_mod_type  (cur_mod),
        .sym_count     (count),
        .mod_err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input int i, input int q);
        logic [15:0] a, c;
        a = i[15:0];
        c = q[15:0];
        return {a, c};
    endfunction

    function automatic int qlv(input logic [1:0] b);
        case (b)
            2'b00:   return -L3;
            2'b01:   return -L;
            2'b10:   return L3;
            default: return L;
        endcase
    endfunction

    function automatic int kbits(input logic [2:0] m);
        case (m)
            3'b001:  return 1;
            3'b011:  return 3;
            3'b010:  return 4;
            default: return 2;
        endcase
    endfunction

    // Points indexed directly by the received Gray code.
    function automatic logic [31:0] map(input logic [2:0] m, input logic [3:0] b);
        case (m)
            3'b001: return b[0] ? pack(-A, 0) : pack(A, 0);
            3'b011: begin
                case (b[2:0])
                    3'b000:  return pack(A, 0);
                    3'b001:  return pack(H, H);
                    3'b011:  return pack(0, A);
                    3'b010:  return pack(-H, H);
                    3'b110:  return pack(-A, 0);
                    3'b111:  return pack(-H, -H);
                    3'b101:  return pack(0, -A);
                    default: return pack(H, -H);
                endcase
            end
            3'b010: return pack(qlv(b[3:2]), qlv(b[1:0]));
            default: return pack(b[1] ? -H : H, b[0] ? -H : H);
        endcase
    endfunction

    task automatic gen(input int k, output logic [3:0] b);
        logic o;
        b = '0;
        for (int i = 0; i < k; i++) begin
            o = m_lfsr[22] ^ m_lfsr[17];
            m_lfsr = {m_lfsr[21:0], o};
            b = {b[2:0], o};
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_mode  = 3'b000;
        m_pend  = 3'b000;
        m_count = '0;
        m_err   = 1'b0;
        m_lfsr  = 23'h7FFFFF;
    endtask

    task automatic model_edge();
        logic [3:0] b;
        logic ld;
        ld = run && (!m_valid || tready);
        if (m_valid && tready) m_count = m_count + 32'd1;
        if (ld) begin
            gen(kbits(m_pend), b);
            m_data  = map(m_pend, b);
            m_mode  = m_pend;
            m_valid = 1'b1;
        end else if (tready) begin
            m_valid = 1'b0;
        end
        if (we) begin
            if (mod_type[2]) m_err = 1'b1;
            else m_pend = mod_type;
        end
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("tvalid", 64'(tvalid), 64'(m_valid));
        cmp("tdata", 64'(tdata), 64'(m_data));
        cmp("cur_mod_type", 64'(cur_mod), 64'(m_mode));
        cmp("sym_count", 64'(count), 64'(m_count));
        cmp("mod_err", 64'(err), 64'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic start_bpsk(input string name);
        mod_type = 3'b001;
        we       = 1'b1;
        run      = 1'b0;
        tready   = 1'b1;
        step();
        we  = 1'b0;
        run = 1'b1;
        step();
        cmp({name, "_tvalid"}, 64'(tvalid), 64'd1);
        cmp({name, "_tdata"}, 64'(tdata), 64'(pack(A, 0)));
        cmp({name, "_mode"}, 64'(cur_mod), 64'd1);
    endtask

    initial begin
        segs[0] = '{mode: 3'b001, nsym: 40,  rdy_pct: 100};
        segs[1] = '{mode: 3'b011, nsym: 60,  rdy_pct: 100};
        segs[2] = '{mode: 3'b010, nsym: 200, rdy_pct: 100};
        segs[3] = '{mode: 3'b000, nsym: 100, rdy_pct: 50};
        segs[4] = '{mode: 3'b011, nsym: 100, rdy_pct: 50};
        segs[5] = '{mode: 3'b010, nsym: 100, rdy_pct: 50};

        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        cmp("reset_tdata", 64'(tdata), 64'd0);
        rst = 1'b0;

        start_bpsk("first_bpsk");

        for (int s = 0; s < 6; s++) begin
            mod_type = segs[s].mode;
            we       = 1'b1;
            step();
            we = 1'b0;
            for (int n = 0; n < segs[s].nsym; n++) begin
                tready = ($urandom_range(99) < segs[s].rdy_pct);
                step();
            end
        end

        tready = 1'b0;
        step();
        cmp("stall_valid", 64'(tvalid), 64'd1);
        mod_type = 3'b110;
        we       = 1'b1;
        step();
        we = 1'b0;
        cmp("bad_write_err", 64'(err), 64'd1);
        repeat (3) step();
        cmp("bad_write_sticky", 64'(err), 64'd1);
        cmp("bad_write_mode", 64'(cur_mod), 64'd2);

        mod_type = 3'b001;
        we       = 1'b1;
        step();
        mod_type = 3'b011;
        step();
        we = 1'b0;
        cmp("stall_mode_held", 64'(cur_mod), 64'd2);
        tready = 1'b1;
        step();
        cmp("two_writes_mode", 64'(cur_mod), 64'd3);

        tready = 1'b0;
        step();
        run = 1'b0;
        step();
        cmp("run0_hold", 64'(tvalid), 64'd1);
        tready = 1'b1;
        step();
        cmp("run0_drain", 64'(tvalid), 64'd0);
        step();
        cmp("run0_idle", 64'(tvalid), 64'd0);

        run = 1'b1;
        repeat (10) step();
        #2;
        rst = 1'b1;
        run = 1'b0;
        #1;
        cmp("rst_async_valid", 64'(tvalid), 64'd0);
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        start_bpsk("restart_bpsk");
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
